// File: rtl/px_scan_sequencer.sv
// px_scan_sequencer
// Steps through the four pixel addresses. For each one it clears the five
// pixel-oscillator counters, runs the oscillators for a fixed gate window, then
// stops them and waits for the pixel-clock domains to settle. It then takes a
// snapshot of the five counts and hands a six-word frame (header + 5 counts) to
// the I2C read registers, one word per master ack.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-low reset
//   start          one-cycle pulse; starts a scan of addresses 0..3 (ignored while busy)
//   counter_val0-4 pixel counter outputs, channels 0..4
//   ack_received   one-cycle pulse: current word read and acked (READOUT only)
//   px_addr        pixel address on all five muxes
//   en_osc_out     mux enable, high only while gating
//   stop_osc       per-channel oscillator stop, all ones except while gating
//   clr_counter    synchronous clear to the counters
//   sample_out     word presented to the I2C read registers
//   drdy           sample_out valid
//   busy           scan in progress
//   done           one-cycle pulse after the last word of address 3 is acked
//   dbg_state      current FSM state (debug visibility only)
//
// Handshake: the word on sample_out is valid while drdy=1. Every ack_received
// pulse seen while drdy=1 consumes the current word. The next word appears on
// sample_out in the cycle after the ack. There is no backpressure and no
// timeout; the block waits for acks indefinitely.
module px_scan_sequencer #(
  parameter int GATE_CYCLES   = 100000,
  parameter int SETTLE_CYCLES = 4,
  parameter int CLR_CYCLES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] counter_val0,
  input  logic [31:0] counter_val1,
  input  logic [31:0] counter_val2,
  input  logic [31:0] counter_val3,
  input  logic [31:0] counter_val4,
  input  logic        ack_received,
  output logic [1:0]  px_addr,
  output logic        en_osc_out,
  output logic [4:0]  stop_osc,
  output logic        clr_counter,
  output logic [31:0] sample_out,
  output logic        drdy,
  output logic        busy,
  output logic        done,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_GATE    = 3'd2,
    S_SETTLE  = 3'd3,
    S_CAPTURE = 3'd4,
    S_READOUT = 3'd5
  } state_t;

  // A state lasting N cycles leaves once the timer has reached N-1.
  localparam logic [19:0] CLR_LAST    = 20'(CLR_CYCLES - 1);
  localparam logic [19:0] GATE_LAST   = 20'(GATE_CYCLES - 1);
  localparam logic [19:0] SETTLE_LAST = 20'(SETTLE_CYCLES - 1);
  localparam logic [31:0] ALL_ONES    = 32'hFFFF_FFFF;

  state_t      state, state_nx;
  logic [19:0] tmr, tmr_nx;
  logic [2:0]  word_idx, word_idx_nx;
  logic [15:0] frame_cnt, frame_cnt_nx;
  logic [4:0]  sat, sat_nx, sat_cap;
  logic [31:0] snap [5];
  logic [31:0] snap_nx [5];

  logic [1:0]  px_addr_nx;
  logic        en_nx, clr_nx, drdy_nx, busy_nx, done_nx;
  logic [4:0]  stop_nx;
  logic [31:0] sample_nx;
  logic        last_word;

  assign dbg_state = state;
  assign last_word = (word_idx == 3'd5);

  // A channel is saturated when its counter sits at all ones at capture time.
  assign sat_cap = {counter_val4 == ALL_ONES, counter_val3 == ALL_ONES,
                    counter_val2 == ALL_ONES, counter_val1 == ALL_ONES,
                    counter_val0 == ALL_ONES};

  function automatic logic [31:0] make_header(input logic [4:0] s,
                                              input logic [1:0] a,
                                              input logic [15:0] fc);
    return {8'hA5, s, 1'b0, a, fc};
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nx;
      tmr   <= tmr_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    tmr_nx   = tmr + 20'd1;
    case (state)
      S_IDLE: begin
        tmr_nx = '0;
        if (start) state_nx = S_CLEAR;
      end
      S_CLEAR: if (tmr == CLR_LAST) begin
        state_nx = S_GATE;
        tmr_nx   = '0;
      end
      S_GATE: if (tmr == GATE_LAST) begin
        state_nx = S_SETTLE;
        tmr_nx   = '0;
      end
      S_SETTLE: if (tmr == SETTLE_LAST) begin
        state_nx = S_CAPTURE;
        tmr_nx   = '0;
      end
      S_CAPTURE: begin
        state_nx = S_READOUT;
        tmr_nx   = '0;
      end
      S_READOUT: begin
        tmr_nx = '0;
        if (ack_received && last_word)
          state_nx = (px_addr == 2'd3) ? S_IDLE : S_CLEAR;
      end
      default: begin
        state_nx = S_IDLE;
        tmr_nx   = '0;
      end
    endcase
  end

  // Output logic: computes next values of the registered outputs.
  // Oscillator controls follow the upcoming state so they change together
  // with the state register.
  always_comb begin
    px_addr_nx   = px_addr;
    word_idx_nx  = word_idx;
    frame_cnt_nx = frame_cnt;
    sat_nx       = sat;
    snap_nx      = snap;
    sample_nx    = sample_out;
    drdy_nx      = drdy;
    busy_nx      = busy;
    done_nx      = 1'b0;
    en_nx        = (state_nx == S_GATE);
    stop_nx      = (state_nx == S_GATE) ? 5'b00000 : 5'b11111;
    clr_nx       = (state_nx == S_CLEAR);
    case (state)
      S_IDLE: if (start) begin
        busy_nx    = 1'b1;
        px_addr_nx = 2'd0;
      end
      S_CAPTURE: begin
        snap_nx     = '{counter_val0, counter_val1, counter_val2,
                        counter_val3, counter_val4};
        sat_nx      = sat_cap;
        word_idx_nx = 3'd0;
        drdy_nx     = 1'b1;
        sample_nx   = make_header(sat_cap, px_addr, frame_cnt);
      end
      S_READOUT: if (ack_received) begin
        if (last_word) begin
          drdy_nx     = 1'b0;
          word_idx_nx = 3'd0;
          if (px_addr == 2'd3) begin
            done_nx      = 1'b1;
            frame_cnt_nx = frame_cnt + 16'd1;
            busy_nx      = 1'b0;
            px_addr_nx   = 2'd0;
          end else begin
            px_addr_nx = px_addr + 2'd1;
          end
        end else begin
          word_idx_nx = word_idx + 3'd1;
          // Word k (1..5) is the snapshot of channel k-1.
          sample_nx   = snap[word_idx];
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      px_addr     <= 2'd0;
      en_osc_out  <= 1'b0;
      stop_osc    <= 5'b11111;
      clr_counter <= 1'b0;
      sample_out  <= '0;
      drdy        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      word_idx    <= '0;
      frame_cnt   <= '0;
      sat         <= '0;
      snap        <= '{default: '0};
    end else begin
      px_addr     <= px_addr_nx;
      en_osc_out  <= en_nx;
      stop_osc    <= stop_nx;
      clr_counter <= clr_nx;
      sample_out  <= sample_nx;
      drdy        <= drdy_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      word_idx    <= word_idx_nx;
      frame_cnt   <= frame_cnt_nx;
      sat         <= sat_nx;
      snap        <= snap_nx;
    end
  end

endmodule
